// File: rtl/ahb_burst_addr_gen.sv
// AHB burst address tracker for the I-cache read path: follows one burst at a time and
// reports the current beat address, line offset, beat index and normalised transfer type.
module ahb_burst_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int MAX_SIZE   = 2,
  parameter int LINE_BYTES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             haddr,
  input  logic [1:0]                    htrans,
  input  logic [2:0]                    hburst,
  input  logic [2:0]                    hsize,
  input  logic                          hready,
  output logic [ADDR_W-1:0]             beat_addr,
  output logic [$clog2(LINE_BYTES)-1:0] line_offset,
  output logic [4:0]                    beat_idx,
  output logic [1:0]                    trans_out,
  output logic                          busy,
  output logic                          burst_done,
  output logic                          err
);

  localparam int         OFF_W      = $clog2(LINE_BYTES);
  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);
  localparam logic [1:0] TR_IDLE    = 2'd0;
  localparam logic [1:0] TR_BUSY    = 2'd1;
  localparam logic [1:0] TR_NONSEQ  = 2'd2;
  localparam logic [1:0] TR_SEQ     = 2'd3;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        idx_q, idx_d;
  logic [1:0]        trans_q, trans_d;
  logic [2:0]        size_q, size_d;
  logic [4:0]        total_q, total_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [4:0]        burst_total;
  logic              burst_wrap;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] wrap_addr;
  logic              crosses_1k;
  logic              final_beat;
  logic              start_req;
  logic              go_idle;

  // Beat count of the incoming burst; zero marks the undefined-length INCR.
  always_comb begin
    burst_total = 5'd0;
    burst_wrap  = 1'b0;
    case (hburst)
      3'd0:    burst_total = 5'd1;
      3'd1:    burst_total = 5'd0;
      3'd2:    begin burst_total = 5'd4;  burst_wrap = 1'b1; end
      3'd3:    burst_total = 5'd4;
      3'd4:    begin burst_total = 5'd8;  burst_wrap = 1'b1; end
      3'd5:    burst_total = 5'd8;
      3'd6:    begin burst_total = 5'd16; burst_wrap = 1'b1; end
      default: burst_total = 5'd16;
    endcase
  end

  // Wrap boundary is total*step, which can be larger than a cache line.
  assign step       = ADDR_W'(1) << size_q;
  assign incr_addr  = addr_q + step;
  assign wrap_mask  = (ADDR_W'(total_q) << size_q) - ADDR_W'(1);
  assign wrap_addr  = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
  assign crosses_1k = incr_addr[ADDR_W-1:10] != addr_q[ADDR_W-1:10];
  assign final_beat = (total_q != 5'd0) && (idx_q == total_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    trans_d   = trans_q;
    size_d    = size_q;
    total_d   = total_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_req = 1'b0;
    go_idle   = 1'b0;

    if (hready) begin
      case (state_q)
        S_IDLE: start_req = (htrans == TR_NONSEQ);
        S_ACTIVE: begin
          if (final_beat) begin
            done_d    = 1'b1;
            go_idle   = 1'b1;
            start_req = (htrans == TR_NONSEQ);
          end else begin
            case (htrans)
              TR_IDLE:   go_idle   = 1'b1;
              TR_BUSY:   trans_d   = TR_BUSY;
              TR_NONSEQ: start_req = 1'b1;
              default: begin
                if (!wrap_q && crosses_1k) begin
                  err_d   = 1'b1;
                  go_idle = 1'b1;
                end else begin
                  addr_d  = wrap_q ? wrap_addr : incr_addr;
                  idx_d   = (idx_q == 5'd31) ? 5'd31 : idx_q + 5'd1;
                  trans_d = TR_SEQ;
                end
              end
            endcase
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_d = S_IDLE;
      idx_d   = 5'd0;
      trans_d = TR_IDLE;
    end

    // A new burst overrides whatever the old one was doing in this cycle.
    if (start_req) begin
      if (hsize > MAX_SIZE_L) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        idx_d   = 5'd0;
        trans_d = TR_IDLE;
      end else begin
        state_d = S_ACTIVE;
        addr_d  = haddr;
        idx_d   = 5'd1;
        trans_d = TR_NONSEQ;
        size_d  = hsize;
        total_d = burst_total;
        wrap_d  = burst_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= 5'd0;
      trans_q <= TR_IDLE;
      size_q  <= 3'd0;
      total_q <= 5'd0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      trans_q <= trans_d;
      size_q  <= size_d;
      total_q <= total_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign beat_addr   = addr_q;
  assign line_offset = addr_q[OFF_W-1:0];
  assign beat_idx    = idx_q;
  assign trans_out   = trans_q;
  assign busy        = (state_q == S_ACTIVE);
  assign burst_done  = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Bench for ahb_burst_addr_gen: an arithmetic burst model checked every cycle, plus
// hand-computed literal expectations along the directed bursts.
module tb_ahb_burst_addr_gen;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3;
  localparam logic [2:0] WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = IDLE;
  logic [2:0]  hburst = SINGLE;
  logic [2:0]  hsize = 3'd0;
  logic        hready = 1'b1;
  logic [31:0] beat_addr;
  logic [3:0]  line_offset;
  logic [4:0]  beat_idx;
  logic [1:0]  trans_out;
  logic        busy, burst_done, err;

  int total_checks = 0;
  int bad_checks   = 0;
  bit check_en     = 1'b0;

  ahb_burst_addr_gen #(.ADDR_W(32), .MAX_SIZE(2), .LINE_BYTES(16)) dut (
    .clk(clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hready(hready), .beat_addr(beat_addr), .line_offset(line_offset),
    .beat_idx(beat_idx), .trans_out(trans_out), .busy(busy),
    .burst_done(burst_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     active;
    longint addr;
    longint step;
    int     total;
    bit     wrap;
    int     idx;
    int     trans;
    bit     done;
    bit     err;
  } model_t;

  model_t m;

  // Next model state from the bus rules, using plain modulo/division arithmetic.
  function automatic model_t step_model(model_t cur, bit r, int tr, int hb, int sz,
                                        longint ad, bit rdy);
    model_t n;
    longint nxt;
    longint b;
    n = cur;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (!rdy) return n;
    if (cur.active) begin
      if (cur.total != 0 && cur.idx == cur.total) begin
        n.done = 1'b1; n.active = 1'b0; n.idx = 0; n.trans = 0;
      end else if (tr == 0) begin
        n.active = 1'b0; n.idx = 0; n.trans = 0;
      end else if (tr == 1) begin
        n.trans = 1;
      end else if (tr == 3) begin
        if (cur.wrap) begin
          b   = cur.total * cur.step;
          nxt = cur.addr - (cur.addr % b) + ((cur.addr + cur.step) % b);
        end else begin
          nxt = (cur.addr + cur.step) % 64'h1_0000_0000;
        end
        if (!cur.wrap && (nxt / 1024) != (cur.addr / 1024)) begin
          n.err = 1'b1; n.active = 1'b0; n.idx = 0; n.trans = 0;
        end else begin
          n.addr  = nxt;
          n.idx   = (cur.idx < 31) ? cur.idx + 1 : 31;
          n.trans = 3;
        end
      end
    end
    if (tr == 2) begin
      if (sz > 2) begin
        n.err = 1'b1; n.active = 1'b0; n.idx = 0; n.trans = 0;
      end else begin
        n.active = 1'b1;
        n.addr   = ad;
        n.step   = longint'(1) << sz;
        n.total  = (hb == 0) ? 1 : (hb == 1) ? 0 : (hb <= 3) ? 4 : (hb <= 5) ? 8 : 16;
        n.wrap   = (hb == 2 || hb == 4 || hb == 6);
        n.idx    = 1;
        n.trans  = 2;
      end
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= step_model(m, rst, int'(htrans), int'(hburst), int'(hsize), longint'(haddr), hready);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("beat_addr", beat_addr, 32'(m.addr));
      checkOutput("line_offset", 32'(line_offset), 32'(m.addr % 16));
      checkOutput("beat_idx", 32'(beat_idx), 32'(m.idx));
      checkOutput("trans_out", 32'(trans_out), 32'(m.trans));
      checkOutput("busy", 32'(busy), 32'(m.active));
      checkOutput("burst_done", 32'(burst_done), 32'(m.done));
      checkOutput("err", 32'(err), 32'(m.err));
    end
  end

  task automatic applyStimulus(input logic [1:0] tr, input logic [2:0] hb, input logic [2:0] hs,
                               input logic [31:0] ad, input logic rdy);
    htrans = tr;
    hburst = hb;
    hsize  = hs;
    haddr  = ad;
    hready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    rst = 1'b1;
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    check_en = 1'b1;
    checkOutput("lit_reset_addr", beat_addr, 32'h0);
    checkOutput("lit_reset_idx", 32'(beat_idx), 32'd0);
    checkOutput("lit_reset_busy", 32'(busy), 32'd0);
    checkOutput("lit_reset_trans", 32'(trans_out), 32'd0);
    rst = 1'b0;

    // WRAP4 word burst wrapping inside 16 bytes
    applyStimulus(NONSEQ, WRAP4, 3'd2, 32'h1008, 1'b1);
    checkOutput("lit_w4_b1", beat_addr, 32'h1008);
    checkOutput("lit_w4_off1", 32'(line_offset), 32'h8);
    applyStimulus(SEQ, WRAP4, 3'd2, 32'h100C, 1'b1);
    checkOutput("lit_w4_b2", beat_addr, 32'h100C);
    applyStimulus(SEQ, WRAP4, 3'd2, 32'h1000, 1'b1);
    checkOutput("lit_w4_b3", beat_addr, 32'h1000);
    checkOutput("lit_w4_off3", 32'(line_offset), 32'h0);
    applyStimulus(SEQ, WRAP4, 3'd2, 32'h1004, 1'b1);
    checkOutput("lit_w4_b4", beat_addr, 32'h1004);
    checkOutput("lit_w4_idx4", 32'(beat_idx), 32'd4);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_w4_done", 32'(burst_done), 32'd1);
    checkOutput("lit_w4_busy", 32'(busy), 32'd0);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_w4_done_gone", 32'(burst_done), 32'd0);

    // INCR8 halfword burst
    applyStimulus(NONSEQ, INCR8, 3'd1, 32'h2000, 1'b1);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(SEQ, INCR8, 3'd1, 32'h2000 + 32'(2 * i), 1'b1);
      exp_addr = 32'h2000 + 32'(2 * i);
      checkOutput("lit_i8_addr", beat_addr, exp_addr);
      checkOutput("lit_i8_idx", 32'(beat_idx), 32'(i + 1));
    end
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_i8_done", 32'(burst_done), 32'd1);

    // WRAP8 word burst with stall after beat 3 and BUSY after beat 5
    applyStimulus(NONSEQ, WRAP8, 3'd2, 32'h301C, 1'b1);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3000, 1'b1);
    checkOutput("lit_w8_b2", beat_addr, 32'h3000);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3004, 1'b1);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3008, 1'b0);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3008, 1'b0);
    checkOutput("lit_w8_stall_addr", beat_addr, 32'h3004);
    checkOutput("lit_w8_stall_idx", 32'(beat_idx), 32'd3);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3008, 1'b1);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h300C, 1'b1);
    applyStimulus(BUSY, WRAP8, 3'd2, 32'h3010, 1'b1);
    checkOutput("lit_w8_busy_trans", 32'(trans_out), 32'd1);
    checkOutput("lit_w8_busy_addr", beat_addr, 32'h300C);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3010, 1'b1);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3014, 1'b1);
    applyStimulus(SEQ, WRAP8, 3'd2, 32'h3018, 1'b1);
    checkOutput("lit_w8_b8", beat_addr, 32'h3018);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_w8_done", 32'(burst_done), 32'd1);

    // INCR across the 1 KB boundary
    applyStimulus(NONSEQ, INCR, 3'd2, 32'h03F8, 1'b1);
    applyStimulus(SEQ, INCR, 3'd2, 32'h03FC, 1'b1);
    applyStimulus(SEQ, INCR, 3'd2, 32'h0400, 1'b1);
    checkOutput("lit_1k_err", 32'(err), 32'd1);
    checkOutput("lit_1k_busy", 32'(busy), 32'd0);
    checkOutput("lit_1k_done", 32'(burst_done), 32'd0);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_1k_err_gone", 32'(err), 32'd0);

    // INCR of 5 beats ended by IDLE
    applyStimulus(NONSEQ, INCR, 3'd0, 32'h0600, 1'b1);
    for (int i = 1; i < 5; i++) applyStimulus(SEQ, INCR, 3'd0, 32'h0600 + 32'(i), 1'b1);
    checkOutput("lit_incr5_addr", beat_addr, 32'h0604);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_incr5_done", 32'(burst_done), 32'd0);
    checkOutput("lit_incr5_busy", 32'(busy), 32'd0);

    // Restart during INCR16, then WRAP4 last beat coinciding with NONSEQ
    applyStimulus(NONSEQ, INCR16, 3'd2, 32'h4000, 1'b1);
    applyStimulus(SEQ, INCR16, 3'd2, 32'h4004, 1'b1);
    applyStimulus(NONSEQ, WRAP4, 3'd2, 32'h5000, 1'b1);
    checkOutput("lit_rs_idx", 32'(beat_idx), 32'd1);
    checkOutput("lit_rs_addr", beat_addr, 32'h5000);
    checkOutput("lit_rs_done", 32'(burst_done), 32'd0);
    applyStimulus(SEQ, WRAP4, 3'd2, 32'h5004, 1'b1);
    applyStimulus(SEQ, WRAP4, 3'd2, 32'h5008, 1'b1);
    applyStimulus(SEQ, WRAP4, 3'd2, 32'h500C, 1'b1);
    applyStimulus(NONSEQ, INCR, 3'd2, 32'h6000, 1'b1);
    checkOutput("lit_co_done", 32'(burst_done), 32'd1);
    checkOutput("lit_co_idx", 32'(beat_idx), 32'd1);
    checkOutput("lit_co_addr", beat_addr, 32'h6000);
    checkOutput("lit_co_busy", 32'(busy), 32'd1);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);

    // Reset in the middle of WRAP16
    applyStimulus(NONSEQ, WRAP16, 3'd2, 32'h7000, 1'b1);
    for (int i = 1; i < 4; i++) applyStimulus(SEQ, WRAP16, 3'd2, 32'h7000 + 32'(4 * i), 1'b1);
    rst = 1'b1;
    applyStimulus(SEQ, WRAP16, 3'd2, 32'h7010, 1'b1);
    rst = 1'b0;
    checkOutput("lit_mr_addr", beat_addr, 32'h0);
    checkOutput("lit_mr_busy", 32'(busy), 32'd0);
    checkOutput("lit_mr_done", 32'(burst_done), 32'd0);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);

    // Unsupported size, stalled NONSEQ, then a byte SINGLE
    applyStimulus(NONSEQ, SINGLE, 3'd3, 32'h8000, 1'b1);
    checkOutput("lit_sz_err", 32'(err), 32'd1);
    checkOutput("lit_sz_busy", 32'(busy), 32'd0);
    applyStimulus(NONSEQ, INCR, 3'd2, 32'h0A00, 1'b0);
    checkOutput("lit_stall_idle_busy", 32'(busy), 32'd0);
    applyStimulus(NONSEQ, SINGLE, 3'd0, 32'h8001, 1'b1);
    checkOutput("lit_single_off", 32'(line_offset), 32'd1);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);
    checkOutput("lit_single_done", 32'(burst_done), 32'd1);

    // Long INCR to reach beat index saturation
    applyStimulus(NONSEQ, INCR, 3'd0, 32'h0900, 1'b1);
    for (int i = 1; i <= 35; i++) applyStimulus(SEQ, INCR, 3'd0, 32'h0900 + 32'(i), 1'b1);
    checkOutput("lit_sat_idx", 32'(beat_idx), 32'd31);
    checkOutput("lit_sat_addr", beat_addr, 32'h0923);
    applyStimulus(IDLE, SINGLE, 3'd0, 32'h0, 1'b1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/ahb_burst_addr_gen.md
Name: ahb_burst_addr_gen

Overview:
- Parametrised successor to the I-cache front-end transfer tracking. It adds all AHB burst types, beat sizes from byte up to MAX_SIZE, BUSY handling, restart and abort.
- Tracks one AHB burst at a time and produces the current beat address, the wrapped line offset, the beat index and a normalised transfer type for the cache read path.
- Sits between the AHB slave port and the cache tag/data lookup.

Parameters:
- ADDR_W, 32, address width in bits.
- MAX_SIZE, 2, largest supported hsize encoding (2 = 32-bit beats).
- LINE_BYTES, 16, cache line size in bytes; power of two and at least 4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- haddr  in  ADDR_W  AHB address.
- htrans  in  2  AHB transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hburst  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- hsize  in  3  beat size encoding; bytes = 1<<hsize.
- hready  in  1  beat accepted when high.
- beat_addr  out  ADDR_W  address of the current beat.
- line_offset  out  log2(LINE_BYTES)  beat_addr modulo LINE_BYTES.
- beat_idx  out  5  beats accepted so far in this burst (1-based for the current beat; 0 when idle).
- trans_out  out  2  normalised transfer type for the current cycle.
- busy  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse on completion of a defined-length burst.
- err  out  1  one-cycle pulse: unsupported hsize, or INCR/INCRx crossing a 1 KB boundary.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE. beat_addr=0, line_offset=0, beat_idx=0, trans_out=IDLE, busy=0, burst_done=0, err=0. Reset overrides any burst in flight; no done or err pulse is generated for it.
- States: IDLE and ACTIVE. All outputs are registered.
- IDLE -> ACTIVE: on htrans=NONSEQ with hready=1. Captured on that edge:
  - beat_addr=haddr;
  - step=1<<hsize;
  - total beats: SINGLE=1, INCR=unbounded, x4=4, x8=8, x16=16;
  - wrap flag;
  - beat_idx=1, trans_out=NONSEQ, busy=1.
- Unsupported hsize: if hsize>MAX_SIZE at NONSEQ, err pulses next cycle, the burst is not started and the state stays IDLE.
- Advance in ACTIVE: on hready=1 with htrans=SEQ:
  - beat_idx increments, trans_out=SEQ;
  - beat_addr becomes the next address (rules below).
- Next-address rules:
  - INCR types: next = beat_addr + step, truncated to ADDR_W.
  - WRAP types: B = total*step; next = (beat_addr & ~(B-1)) | ((beat_addr + step) & (B-1)).
  - 1 KB crossing on an INCR type (next[ADDR_W-1:10] differs from beat_addr[ADDR_W-1:10]): err pulses, the state returns to IDLE, and no done pulse is produced.
- Completion:
  - The final beat (beat_idx == total) is accepted with hready=1: burst_done=1 for exactly the next cycle, then state IDLE, busy=0, trans_out=IDLE, beat_idx=0. beat_addr holds its last value.
  - SINGLE completes on the beat after the NONSEQ acceptance, with no SEQ needed.
  - INCR (undefined length) never asserts burst_done.
- Stall: hready=0 holds all state and outputs unchanged.
- BUSY in ACTIVE: trans_out=BUSY and no advance; the address and beat index are held. The next SEQ resumes the burst.
- Abort: htrans=IDLE while ACTIVE with hready=1 returns to IDLE with no burst_done. This is the normal termination for INCR.
- Restart: NONSEQ while ACTIVE with hready=1 aborts the current burst (no done) and starts the new one in the same cycle, with beat_idx=1.
- Simultaneous final beat and NONSEQ: burst_done pulses for the old burst and the new burst starts in that same cycle.
- Width rules:
  - line_offset is always beat_addr[log2(LINE_BYTES)-1:0].
  - beat_idx saturates at 31 for INCR bursts.
  - The WRAP boundary B may exceed LINE_BYTES (for example WRAP16 word = 64 B); B is applied as specified.

Test Plan:
- WRAP4, hsize=2, NONSEQ at 0x1008, then 3 SEQ with hready=1 -> beat_addr 0x1008, 0x100C, 0x1000, 0x1004; line_offset 8, C, 0, 4; burst_done pulses once, one cycle after the 4th beat; busy falls with it.
- INCR8, hsize=1, NONSEQ at 0x2000 -> addresses 0x2000 to 0x200E in steps of 2; beat_idx 1..8; single done pulse.
- WRAP8, hsize=2 at 0x301C, with hready=0 for 2 cycles after beat 3 and one BUSY cycle after beat 5 -> outputs frozen while stalled, trans_out=BUSY in the BUSY cycle; sequence 0x301C, 0x3000, 0x3004 ... 0x3018; done after 8 beats.
- INCR at 0x3F8, hsize=2, SEQs across 0x400 -> err pulse on the crossing attempt, state IDLE, no done. Separately, INCR ended by htrans=IDLE after 5 beats -> no done, busy=0.
- Restart: NONSEQ at 0x5000 during beat 2 of an INCR16 -> beat_idx=1, beat_addr=0x5000, no done for the aborted burst. Coincident last beat of WRAP4 with NONSEQ -> done pulse and the new burst start in the same cycle.
- rst=1 mid-WRAP16 -> all outputs zero on the next edge, no done. Separately, NONSEQ with hsize=3 -> err pulse, busy stays 0.
